// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory bus master.
package dmem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_RD_ISSUE   = 2'd2,
    ST_RD_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_bus_tristate.sv
// Tri-state pad driver for the shared memory data bus; isolated so a vendor
// I/O primitive can replace it without touching the controller.
module bus_tristate #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  inout  wire  [DATA_WIDTH-1:0] pad
);

  assign pad = en ? din : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/dmem_master.sv
// Single-request bus master between the load/store unit and a single-port
// synchronous data memory: sequences cs/we/oe and owns the bus during writes.
module dmem_master
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_resp_valid;
  logic                  w_cs;
  logic                  w_we;
  logic                  w_oe;
  logic                  w_accept;
  logic                  w_drive;

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_drive  = (r_state == ST_WRITE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:       if (req_valid) w_next_state = req_we ? ST_WRITE : ST_RD_ISSUE;
      ST_WRITE:      w_next_state = ST_IDLE;
      ST_RD_ISSUE:   w_next_state = ST_RD_CAPTURE;
      ST_RD_CAPTURE: w_next_state = ST_IDLE;
      default:       w_next_state = ST_IDLE;
    endcase
  end

  // Strobes decode the next state so the registered copies line up with it.
  always_comb begin
    w_cs = 1'b0;
    w_we = 1'b0;
    w_oe = 1'b0;
    case (w_next_state)
      ST_WRITE: begin
        w_cs = 1'b1;
        w_we = 1'b1;
      end
      ST_RD_ISSUE, ST_RD_CAPTURE: begin
        w_cs = 1'b1;
        w_oe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs         <= 1'b0;
      r_we         <= 1'b0;
      r_oe         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      r_cs         <= w_cs;
      r_we         <= w_we;
      r_oe         <= w_oe;
      r_resp_valid <= (r_state == ST_WRITE) || (r_state == ST_RD_CAPTURE);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // The memory registered its data one edge earlier; take it now.
      if (r_state == ST_RD_CAPTURE) r_rdata <= mem_data;
    end
  end

  bus_tristate #(.DATA_WIDTH(DATA_WIDTH)) u_mem_data_io (
    .en  (w_drive),
    .din (r_wdata),
    .pad (mem_data)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign mem_addr   = r_addr;
  assign mem_cs     = r_cs;
  assign mem_we     = r_we;
  assign mem_oe     = r_oe;

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: synchronous RAM on the bus, a transaction-level
// model compared every cycle, and directed scenarios with literal expectations.
module tb_dmem_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic [7:0] mem_addr;
  logic       mem_cs;
  logic       mem_we;
  logic       mem_oe;
  wire  [7:0] mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_data   (mem_data)
  );

  // Single-port synchronous RAM: registered read, drives only when cs & oe & !we.
  logic [7:0] ram [256];
  logic [7:0] ram_q = 8'h00;
  logic       ram_drive;
  assign ram_drive = mem_cs && mem_oe && !mem_we;
  assign mem_data  = ram_drive ? ram_q : 8'bz;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_data;
      else        ram_q <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transaction model: cycles left in the current operation and expected results.
  int         m_left = 0;
  bit         m_is_read = 1'b0;
  bit         m_resp = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] m_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]   = 8'h00;
      m_mem[i] = 8'h00;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = 0;
      m_resp  = 1'b0;
      m_rdata = 8'h00;
    end else begin
      m_resp = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_resp = 1'b1;
          if (m_is_read) m_rdata = m_mem[m_addr];
        end
      end else if (req_valid) begin
        m_addr    = req_addr;
        m_wdata   = req_wdata;
        m_is_read = !req_we;
        if (req_we) begin
          m_mem[req_addr] = req_wdata;
          m_left = 1;
        end else begin
          m_left = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit w_phase;
    bit c_phase;
    w_phase = (m_left == 1) && !m_is_read;
    c_phase = (m_left == 1) && m_is_read;
    check("req_ready", 32'(req_ready), 32'(m_left == 0));
    check("resp_valid", 32'(resp_valid), 32'(m_resp));
    check("resp_rdata", 32'(resp_rdata), 32'(m_rdata));
    check("mem_cs", 32'(mem_cs), 32'(m_left > 0));
    check("mem_we", 32'(mem_we), 32'(w_phase));
    check("mem_oe", 32'(mem_oe), 32'((m_left > 0) && m_is_read));
    check("bus_drive_en", 32'(dut.u_mem_data_io.en), 32'(w_phase));
    check("bus_contention", 32'(dut.u_mem_data_io.en && ram_drive), 32'(0));
    if (m_left > 0) check("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (w_phase)    check("bus_wdata", 32'(mem_data), 32'(m_wdata));
    if (c_phase)    check("bus_rdata", 32'(mem_data), 32'(m_mem[m_addr]));
  end

  // Issue one request from a negedge; returns at the negedge showing resp_valid.
  // Inputs are scrambled after acceptance so only the latched copies can matter.
  task automatic xfer(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                      input string name);
    int k;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    k = 1;
    while (!resp_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 32'(k), we ? 32'd2 : 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int t [3];

    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_rdata", 32'(resp_rdata), 32'h00);
    check("rst mem_addr", 32'(mem_addr), 32'h00);
    check("rst strobes", 32'({mem_cs, mem_we, mem_oe}), 32'd0);
    check("rst bus_en", 32'(dut.u_mem_data_io.en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read.
    xfer(1'b1, 8'h10, 8'hA5, "wr10");
    xfer(1'b0, 8'h10, 8'h00, "rd10");
    check("rd10 data", 32'(resp_rdata), 32'hA5);

    // Back-to-back writes with req_valid held high.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h00; req_wdata = 8'h01;
    pulses = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) begin
        if (pulses < 3) t[pulses] = n;
        pulses++;
      end
      if (n == 1) begin req_addr = 8'h01; req_wdata = 8'h02; end
      if (n == 3) begin req_addr = 8'hFF; req_wdata = 8'h03; end
      if (n == 5) req_valid = 1'b0;
    end
    check("b2b pulses", 32'(pulses), 32'd3);
    check("b2b first ack", 32'(t[0]), 32'd2);
    check("b2b spacing1", 32'(t[1] - t[0]), 32'd2);
    check("b2b spacing2", 32'(t[2] - t[1]), 32'd2);
    xfer(1'b0, 8'h00, 8'h00, "rd00");
    check("rd00 data", 32'(resp_rdata), 32'h01);
    xfer(1'b0, 8'h01, 8'h00, "rd01");
    check("rd01 data", 32'(resp_rdata), 32'h02);
    xfer(1'b0, 8'hFF, 8'h00, "rdFF");
    check("rdFF data", 32'(resp_rdata), 32'h03);

    // Write accepted in the resp_valid cycle of a read.
    xfer(1'b0, 8'h10, 8'h00, "rd10b");
    check("rd10b data", 32'(resp_rdata), 32'hA5);
    xfer(1'b1, 8'h10, 8'h3C, "wr10b");
    check("wr keeps rdata", 32'(resp_rdata), 32'hA5);
    xfer(1'b0, 8'h10, 8'h00, "rd10c");
    check("rd10c data", 32'(resp_rdata), 32'h3C);

    // Request while busy is ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    check("busy ready", 32'(req_ready), 32'd0);
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'hEE;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      if (resp_valid) begin
        pulses++;
        check("busy rdata", 32'(resp_rdata), 32'h3C);
      end
    end
    check("busy pulses", 32'(pulses), 32'd1);
    xfer(1'b0, 8'h20, 8'h00, "rd20");
    check("rd20 untouched", 32'(resp_rdata), 32'h00);

    // Reset during RD_CAPTURE.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre-abort oe", 32'(mem_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort cs", 32'(mem_cs), 32'd0);
    check("abort oe", 32'(mem_oe), 32'd0);
    check("abort resp_valid", 32'(resp_valid), 32'd0);
    check("abort bus_en", 32'(dut.u_mem_data_io.en), 32'd0);
    check("abort ram_drive", 32'(ram_drive), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post-rst ready", 32'(req_ready), 32'd1);
    xfer(1'b0, 8'h10, 8'h00, "rd10d");
    check("rd10d data", 32'(resp_rdata), 32'h3C);

    // Address boundary.
    xfer(1'b1, 8'hFF, 8'h7E, "wrFF");
    xfer(1'b0, 8'hFF, 8'h00, "rdFFb");
    check("rdFFb data", 32'(resp_rdata), 32'h7E);
    xfer(1'b0, 8'h00, 8'h00, "rd00b");
    check("rd00b data", 32'(resp_rdata), 32'h01);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
